// File: rtl/hbb_mux1hot_pkg.sv
// rtl/hbb_mux1hot_pkg.sv - one-hot-with-default select decode shared by mux and demux sides
package hbb_mux1hot_pkg;

  localparam int NUM_PORTS = 8;
  localparam int DFLT_IDX  = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } sel_dec_t;

  // Scans downward so the lowest set bit is the last one written and wins.
  function automatic sel_dec_t lowest_one_idx(input logic [NUM_PORTS-1:0] sel);
    sel_dec_t r;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (sel[i]) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage1.sv
// rtl/pipe_stage1.sv - one-entry valid/ready pipeline register
module pipe_stage1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             free
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign free     = !valid_q || ready;
  assign valid    = valid_q;
  assign data_out = data_q;

  // Load is only issued while free, so a load always wins over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_in;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1hot_with_default8.sv
// rtl/demux1hot_with_default8.sv - registered 1-to-8 one-hot demux with default sink
module demux1hot_with_default8
  import hbb_mux1hot_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [7:0]           in_sel,
  output logic [7:0]           out_valid,
  input  logic [7:0]           out_ready,
  output logic [8*WIDTH-1:0]   out_data,
  output logic                 dflt_valid,
  input  logic                 dflt_ready,
  output logic [WIDTH-1:0]     dflt_data,
  output logic [CNT_W-1:0]     dflt_cnt,
  input  logic                 dflt_cnt_clr
);

  sel_dec_t         dec;
  logic [3:0]       tgt_idx;
  logic             accept;
  logic [8:0]       st_load;
  logic [8:0]       st_ready;
  logic [8:0]       st_valid;
  logic [8:0]       st_free;
  logic [WIDTH-1:0] st_data [9];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign dec      = lowest_one_idx(in_sel);
  assign tgt_idx  = dec.found ? {1'b0, dec.idx} : 4'(DFLT_IDX);
  assign st_ready = {dflt_ready, out_ready};
  assign in_ready = st_free[tgt_idx];
  assign accept   = in_valid && in_ready;
  assign st_load  = accept ? (9'b1 << tgt_idx) : 9'b0;

  for (genvar g = 0; g <= DFLT_IDX; g++) begin : g_stage
    pipe_stage1 #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (st_load[g]),
      .data_in  (in_data),
      .ready    (st_ready[g]),
      .valid    (st_valid[g]),
      .data_out (st_data[g]),
      .free     (st_free[g])
    );
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pack
    assign out_data[g*WIDTH +: WIDTH] = st_data[g];
  end

  assign out_valid  = st_valid[7:0];
  assign dflt_valid = st_valid[DFLT_IDX];
  assign dflt_data  = st_data[DFLT_IDX];

  // Clear beats increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (dflt_cnt_clr) begin
      cnt_d = '0;
    end else if (accept && !dec.found && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign dflt_cnt = cnt_q;

endmodule

// File: doc/demux1hot_with_default8.md
Name: demux1hot_with_default8

Overview:
- Registered 1-to-8 demultiplexer with a default sink.
- Routes each accepted input beat to one of eight output ports, chosen by a one-hot select. The lowest set bit wins; an all-zero select routes to the default port.
- Each output port has valid/ready flow control and a one-entry pipeline register. Sits on the producer side of an 8-input one-hot-with-default mux datapath, fanning one stream out to eight consumers.

Parameters:
- WIDTH, 1, data width of the input and of each output port.
- CNT_W, 8, width of the saturating default-route beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WIDTH  input payload.
- in_sel  input  8  routing select; lowest set bit chooses the port; 0 selects default.
- out_valid  output  8  per-port valid; bit i belongs to port i.
- out_ready  input  8  per-port ready.
- out_data  output  8*WIDTH  packed payloads; port i occupies bits [i*WIDTH +: WIDTH].
- dflt_valid  output  1  default-port valid.
- dflt_ready  input  1  default-port ready.
- dflt_data  output  WIDTH  default-port payload.
- dflt_cnt  output  CNT_W  saturating count of beats accepted to the default port.
- dflt_cnt_clr  input  1  synchronous clear of dflt_cnt.

Behaviour:
- Reset (async assert, sync-safe deassert via rst_n): all out_valid = 0, dflt_valid = 0, all data registers = 0, dflt_cnt = 0.
- Target decode (combinational):
  - tgt = port index of the lowest set bit of in_sel.
  - in_sel == 0 -> target is the default port.
  - Bits above the lowest set bit are ignored; multi-hot selects are legal.
- Each of the 9 ports (8 outputs + default) has one stage register, full or empty.
  - stage_free = !valid || ready.
- in_ready = stage_free of the target port only. It depends combinationally on in_sel and that port's ready, not on in_valid.
- Accept (in_valid && in_ready): the target stage loads in_data and sets valid at the next clock edge. Latency is exactly 1 cycle.
- Drain: a stage with valid && ready and no load in the same cycle clears valid at the next edge.
- Simultaneous drain and load on the same port: the stage stays valid and holds the new data. This gives full throughput of 1 beat/cycle per port.
- Non-target ports are unaffected by accepts. They keep draining independently, so several ports can hold data at once.
- Holding rule: while out_valid[i] && !out_ready[i], out_data[i] is stable. Input stall back-pressures only beats aimed at that port.
- in_sel and in_data are don't-care when in_valid = 0; no stage state changes.
- dflt_cnt:
  - Increments by 1 on each accept routed to the default port.
  - Saturates at 2^CNT_W - 1.
  - dflt_cnt_clr has priority over increment: clear and accept in the same cycle leaves the count at 0.
  - Registered; the new value is visible the cycle after the accept.
- Reset mid-operation: any buffered beats are discarded, valids drop immediately (async), and the counter is cleared.
- No X propagation: out_data of empty stages holds its last loaded value, or 0 after reset.

Decomposition:
- Shared package (hbb_mux1hot_pkg):
  - NUM_PORTS = 8.
  - DFLT_IDX = 8.
  - function lowest_one_idx(sel) returning {found, idx[2:0]}.
  - Shared with the mux side so select semantics match bit-for-bit.
- Sub-module pipe_stage1: parameter WIDTH; ports clk, rst_n, load, data_in, ready, valid, data_out, free. Instantiated 9 times via generate (8 outputs + default).
- Top level holds the decode, in_ready selection, and counter.

Test Plan:
- Reset: rst_n = 0 mid-stream with port 3 full -> out_valid = 0, dflt_cnt = 0 immediately; out_data[3] = 0 after release.
- Priority routing, all out_ready = 1:
  - in_sel = 8'b0010_1100, in_data = 8'hA5, WIDTH = 8 -> next cycle out_valid = 8'b0000_0100, out_data[2] = A5; ports 3 and 5 untouched.
- Default route:
  - Three beats with in_sel = 0, dflt_ready = 1 -> dflt_valid pulses each following cycle and dflt_cnt = 3.
  - dflt_cnt_clr asserted with a 4th default beat -> dflt_cnt = 0.
- Back-pressure isolation:
  - out_ready[1] = 0 and port 1 full -> in_ready = 0 for in_sel = 8'h02, while in_sel = 8'h10 is accepted the same cycle.
  - out_data[1] is held until out_ready[1] = 1.
- Throughput: out_ready[7] = 1 and back-to-back beats 1,2,3,4 to port 7 -> in_ready stays 1 and out_data[7] = 1,2,3,4 on consecutive cycles.
- Saturation: CNT_W = 2, five default beats -> dflt_cnt sequence 1,2,3,3,3.
